// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard inputs from the pipeline and control outputs back to it
interface pipeline_hazard_ctrl_if;
  logic [4:0] ID_rs1;
  logic [4:0] ID_rs2;
  logic [4:0] ID_EX_rd;
  logic       ID_EX_mem_read;
  logic       branch_taken;
  logic       EX_MEM_mem_req;
  logic       dmem_ready;
  logic       pc_write;
  logic       pc_src;
  logic       IF_flush;
  logic       IF_ID_write;
  logic       ID_EX_flush;
  logic       pipe_en;
  logic       mem_timeout;
  modport master (
    output ID_rs1, ID_rs2, ID_EX_rd, ID_EX_mem_read, branch_taken, EX_MEM_mem_req, dmem_ready,
    input  pc_write, pc_src, IF_flush, IF_ID_write, ID_EX_flush, pipe_en, mem_timeout
  );
  modport slave (
    input  ID_rs1, ID_rs2, ID_EX_rd, ID_EX_mem_read, branch_taken, EX_MEM_mem_req, dmem_ready,
    output pc_write, pc_src, IF_flush, IF_ID_write, ID_EX_flush, pipe_en, mem_timeout
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use stall, branch flush and memory freeze control for the 5-stage core.
// Optional HAZARD_PERF_CNT_EN adds stall_cycles/flush_events counters.
module pipeline_hazard_ctrl #(
  parameter int FLUSH_DEPTH = 1,
  parameter int MEM_TIMEOUT = 255
) (
  input logic clk,
  input logic reset_n,
  pipeline_hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
`endif
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH} state_t;
  state_t state, eff;
  logic [2:0] flush_cnt;
  logic [7:0] wait_cnt;
  logic resume_flush, raw_freeze, timeout_hit, freeze, load_use, branch, flushing, stall;
  // the MEM_WAIT exit cycle decodes as the state being resumed
  always_comb begin
    raw_freeze = hz.EX_MEM_mem_req & ~hz.dmem_ready;
    timeout_hit = (state == MEM_WAIT) && (wait_cnt == 8'(MEM_TIMEOUT));
    freeze = raw_freeze & ~timeout_hit;
    eff = (state == MEM_WAIT) ? (resume_flush ? FLUSH : RUN) : state;
    load_use = hz.ID_EX_mem_read && (hz.ID_EX_rd != 5'd0) &&
               ((hz.ID_EX_rd == hz.ID_rs1) || (hz.ID_EX_rd == hz.ID_rs2));
    branch = ~freeze & (eff == RUN) & hz.branch_taken;
    flushing = ~freeze & (eff == FLUSH);
    stall = ~freeze & (eff == RUN) & ~hz.branch_taken & load_use;
    hz.pc_write = ~freeze & ~stall;
    hz.pc_src = branch;
    hz.IF_flush = branch | flushing;
    hz.IF_ID_write = ~freeze & ~stall;
    hz.ID_EX_flush = branch | stall;
    hz.pipe_en = ~freeze;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
      flush_cnt <= '0;
      wait_cnt <= '0;
      resume_flush <= 1'b0;
      hz.mem_timeout <= 1'b0;
    end else if (freeze) begin
      state <= MEM_WAIT;
      wait_cnt <= wait_cnt + 8'd1;
      if (state == FLUSH) resume_flush <= 1'b1;
    end else begin
      wait_cnt <= '0;
      resume_flush <= 1'b0;
      if (timeout_hit) hz.mem_timeout <= 1'b1;
      if (eff == FLUSH) begin
        flush_cnt <= flush_cnt - 3'd1;
        state <= (flush_cnt <= 3'd1) ? RUN : FLUSH;
      end else if (hz.branch_taken && FLUSH_DEPTH > 0) begin
        state <= FLUSH;
        flush_cnt <= 3'(FLUSH_DEPTH);
      end else begin
        state <= RUN;
      end
    end
  end
`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (freeze | stall) stall_cycles <= stall_cycles + 32'd1;
      if (branch) flush_events <= flush_events + 32'd1;
    end
  end
`endif
endmodule
